// File: rtl/bypass_rx_dma.sv
// Raw Ethernet bypass RX: store-and-forward frame buffer, per-region host ring
// allocation, then one write command plus its data burst per committed frame.
module bypass_rx_dma #(
  parameter int N_REGIONS  = 4,
  parameter int BUF_BEATS  = 512,
  parameter int MAX_BEATS  = 150,
  parameter int META_DEPTH = 16,
  parameter int VADDR_BITS = 48,
  parameter int LEN_BITS   = 28,
  localparam int N_REGIONS_BITS = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [511:0]                    s_axis_rx_tdata,
  input  logic [63:0]                     s_axis_rx_tkeep,
  input  logic                            s_axis_rx_tlast,
  input  logic [N_REGIONS_BITS-1:0]       s_axis_rx_tid,
  input  logic                            s_axis_rx_tvalid,
  output logic                            s_axis_rx_tready,
  output logic                            m_rq_wr_valid,
  input  logic                            m_rq_wr_ready,
  output logic [VADDR_BITS-1:0]           m_rq_wr_vaddr,
  output logic [LEN_BITS-1:0]             m_rq_wr_len,
  output logic [N_REGIONS_BITS-1:0]       m_rq_wr_vfid,
  output logic                            m_rq_wr_host,
  output logic                            m_rq_wr_last,
  output logic [511:0]                    m_axis_wr_tdata,
  output logic [63:0]                     m_axis_wr_tkeep,
  output logic                            m_axis_wr_tlast,
  output logic [N_REGIONS_BITS-1:0]       m_axis_wr_tid,
  output logic [N_REGIONS_BITS-1:0]       m_axis_wr_tdest,
  output logic                            m_axis_wr_tvalid,
  input  logic                            m_axis_wr_tready,
  input  logic [N_REGIONS-1:0]            cfg_en,
  input  logic [N_REGIONS*VADDR_BITS-1:0] cfg_ring_base,
  input  logic [N_REGIONS*32-1:0]         cfg_ring_bytes,
  output logic [31:0]                     stat_frames,
  output logic [31:0]                     stat_drops
);
  localparam int AW  = $clog2(BUF_BEATS);
  localparam int PW  = AW + 1;
  localparam int MAW = $clog2(META_DEPTH);
  localparam int BW  = $clog2(MAX_BEATS + 1);
  localparam int NRP = 2 ** N_REGIONS_BITS;

  typedef struct packed {
    logic [N_REGIONS_BITS-1:0] vfid;
    logic [13:0]               len;
    logic [BW-1:0]             beats;
  } meta_t;

  typedef enum logic [1:0] {I_IDLE, I_PASS, I_DROP} ist_t;
  typedef enum logic [1:0] {E_IDLE, E_CMD, E_DATA} est_t;

  function automatic logic [6:0] popcnt(input logic [63:0] k);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + 7'(k[i]);
    return c;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic [N_REGIONS-1:0][VADDR_BITS-1:0] base_a;
  logic [N_REGIONS-1:0][31:0]           bytes_a;
  logic [NRP-1:0]                       en_pad;
  assign base_a = cfg_ring_base;
  assign bytes_a = cfg_ring_bytes;
  assign en_pad = NRP'(cfg_en);

  ist_t                      ist_q, ist_d;
  logic [PW-1:0]             wr_q, wr_d, cmt_q, cmt_d, rd_q, rd_d;
  logic [BW-1:0]             cnt_q, cnt_d;
  logic [13:0]               len_q, len_d;
  logic [N_REGIONS_BITS-1:0] in_vfid_q, in_vfid_d;
  logic [31:0]               frames_q, frames_d, drops_q, drops_d;
  logic                      buf_we, meta_push, meta_pop, meta_full, meta_empty;
  meta_t                     meta_in, meta_out;
  logic [MAW:0]              mw_q, mw_d, mr_q, mr_d;

  est_t                       est_q, est_d;
  logic [N_REGIONS_BITS-1:0]  ev_q, ev_d;
  logic [13:0]                elen_q, elen_d;
  logic [BW-1:0]              ebeats_q, ebeats_d, beat_q, beat_d;
  logic [VADDR_BITS-1:0]      vaddr_q, vaddr_d;
  logic [31:0]                roff_new_q, roff_new_d;
  logic [N_REGIONS-1:0][31:0] ring_off_q, ring_off_d;

  logic [575:0] buf_mem [BUF_BEATS];
  meta_t        meta_mem [META_DEPTH];
  logic [575:0] rdata_q;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] used;
  logic [6:0]    pc;
  logic          free_ok, start_ok, e_last;
  logic [14:0]   rlen;
  logic [32:0]   fit;
  logic [31:0]   off;

  assign s_axis_rx_tready = 1'b1;
  assign used       = wr_q - rd_q;
  assign free_ok    = (32'(used) + 32'(MAX_BEATS)) <= 32'(BUF_BEATS);
  assign meta_full  = (mw_q - mr_q) == (MAW+1)'(META_DEPTH);
  assign meta_empty = (mw_q == mr_q);
  assign meta_out   = meta_mem[mr_q[MAW-1:0]];
  assign start_ok   = en_pad[s_axis_rx_tid] && free_ok && !meta_full;
  assign pc         = popcnt(s_axis_rx_tkeep);

  // Ingress: speculative write, commit on tlast, roll back on overlength.
  always_comb begin
    ist_d = ist_q; wr_d = wr_q; cmt_d = cmt_q; cnt_d = cnt_q; len_d = len_q;
    in_vfid_d = in_vfid_q; frames_d = frames_q; drops_d = drops_q;
    buf_we = 1'b0; meta_push = 1'b0; meta_in = '0;
    case (ist_q)
      I_IDLE: if (s_axis_rx_tvalid) begin
        in_vfid_d = s_axis_rx_tid;
        if (start_ok) begin
          buf_we = 1'b1; wr_d = wr_q + PW'(1); cnt_d = BW'(1); len_d = 14'(pc);
          if (s_axis_rx_tlast) begin
            cmt_d = wr_d; meta_push = 1'b1; frames_d = sat_inc(frames_q);
          end else ist_d = I_PASS;
        end else if (s_axis_rx_tlast) drops_d = sat_inc(drops_q);
        else ist_d = I_DROP;
      end
      I_PASS: if (s_axis_rx_tvalid) begin
        if (cnt_q == BW'(MAX_BEATS)) begin
          wr_d = cmt_q;
          if (s_axis_rx_tlast) begin
            drops_d = sat_inc(drops_q); ist_d = I_IDLE;
          end else ist_d = I_DROP;
        end else begin
          buf_we = 1'b1; wr_d = wr_q + PW'(1); cnt_d = cnt_q + BW'(1);
          len_d = len_q + 14'(pc);
          if (s_axis_rx_tlast) begin
            cmt_d = wr_d; meta_push = 1'b1; frames_d = sat_inc(frames_q); ist_d = I_IDLE;
          end
        end
      end
      I_DROP: if (s_axis_rx_tvalid && s_axis_rx_tlast) begin
        drops_d = sat_inc(drops_q); ist_d = I_IDLE;
      end
      default: ist_d = I_IDLE;
    endcase
    if (meta_push) meta_in = '{vfid: in_vfid_d, len: len_d, beats: cnt_d};
  end

  assign mw_d = mw_q + (MAW+1)'(meta_push);
  assign mr_d = mr_q + (MAW+1)'(meta_pop);
  assign e_last = (beat_q == ebeats_q - BW'(1));

  // Egress: the ring slot is chosen at pop time so a frame never straddles the wrap.
  always_comb begin
    est_d = est_q; ev_d = ev_q; elen_d = elen_q; ebeats_d = ebeats_q; beat_d = beat_q;
    vaddr_d = vaddr_q; roff_new_d = roff_new_q; ring_off_d = ring_off_q; rd_d = rd_q;
    meta_pop = 1'b0;
    rlen = (15'(meta_out.len) + 15'd63) & ~15'd63;
    fit  = 33'(ring_off_q[meta_out.vfid]) + 33'(rlen);
    off  = (fit > 33'(bytes_a[meta_out.vfid])) ? 32'd0 : ring_off_q[meta_out.vfid];
    case (est_q)
      E_IDLE: if (!meta_empty) begin
        meta_pop = 1'b1; ev_d = meta_out.vfid; elen_d = meta_out.len;
        ebeats_d = meta_out.beats;
        vaddr_d = base_a[meta_out.vfid] + VADDR_BITS'(off);
        roff_new_d = off + 32'(rlen); est_d = E_CMD;
      end
      E_CMD: begin
        beat_d = '0;
        if (m_rq_wr_ready) begin
          ring_off_d[ev_q] = roff_new_q; est_d = E_DATA;
        end
      end
      E_DATA: if (m_axis_wr_tready) begin
        if (e_last) begin
          rd_d = rd_q + PW'(ebeats_q); est_d = E_IDLE;
        end else beat_d = beat_q + BW'(1);
      end
      default: est_d = E_IDLE;
    endcase
  end

  // The output register re-reads the current beat while stalled, keeping data stable.
  assign rd_addr = AW'(rd_q + PW'(beat_d));

  always_ff @(posedge aclk) begin
    if (buf_we) buf_mem[wr_q[AW-1:0]] <= {s_axis_rx_tkeep, s_axis_rx_tdata};
    if (meta_push) meta_mem[mw_q[MAW-1:0]] <= meta_in;
    rdata_q <= buf_mem[rd_addr];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ist_q <= I_IDLE; wr_q <= '0; cmt_q <= '0; rd_q <= '0; cnt_q <= '0; len_q <= '0;
      in_vfid_q <= '0; frames_q <= '0; drops_q <= '0; mw_q <= '0; mr_q <= '0;
      est_q <= E_IDLE; ev_q <= '0; elen_q <= '0; ebeats_q <= '0; beat_q <= '0;
      vaddr_q <= '0; roff_new_q <= '0; ring_off_q <= '0;
    end else begin
      ist_q <= ist_d; wr_q <= wr_d; cmt_q <= cmt_d; rd_q <= rd_d; cnt_q <= cnt_d; len_q <= len_d;
      in_vfid_q <= in_vfid_d; frames_q <= frames_d; drops_q <= drops_d; mw_q <= mw_d; mr_q <= mr_d;
      est_q <= est_d; ev_q <= ev_d; elen_q <= elen_d; ebeats_q <= ebeats_d; beat_q <= beat_d;
      vaddr_q <= vaddr_d; roff_new_q <= roff_new_d; ring_off_q <= ring_off_d;
    end
  end

  assign m_rq_wr_valid    = (est_q == E_CMD);
  assign m_rq_wr_vaddr    = vaddr_q;
  assign m_rq_wr_len      = LEN_BITS'(elen_q);
  assign m_rq_wr_vfid     = ev_q;
  assign m_rq_wr_host     = 1'b1;
  assign m_rq_wr_last     = 1'b1;
  assign m_axis_wr_tvalid = (est_q == E_DATA);
  assign m_axis_wr_tdata  = rdata_q[511:0];
  assign m_axis_wr_tkeep  = rdata_q[575:512];
  assign m_axis_wr_tlast  = e_last;
  assign m_axis_wr_tid    = ev_q;
  assign m_axis_wr_tdest  = '0;
  assign stat_frames      = frames_q;
  assign stat_drops       = drops_q;
endmodule

// File: tb/tb_bypass_rx_dma.sv
// Scoreboard bench for bypass_rx_dma: stimulus pushes expected commands and
// beats, an independent monitor pops and compares on every output handshake.
module tb_bypass_rx_dma;
  localparam int NR = 4;
  localparam int VB = 48;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [511:0] s_axis_rx_tdata;
  logic [63:0]  s_axis_rx_tkeep;
  logic         s_axis_rx_tlast, s_axis_rx_tvalid, s_axis_rx_tready;
  logic [1:0]   s_axis_rx_tid;
  logic         m_rq_wr_valid, m_rq_wr_ready, m_rq_wr_host, m_rq_wr_last;
  logic [VB-1:0] m_rq_wr_vaddr;
  logic [27:0]  m_rq_wr_len;
  logic [1:0]   m_rq_wr_vfid;
  logic [511:0] m_axis_wr_tdata;
  logic [63:0]  m_axis_wr_tkeep;
  logic         m_axis_wr_tlast, m_axis_wr_tvalid, m_axis_wr_tready;
  logic [1:0]   m_axis_wr_tid, m_axis_wr_tdest;
  logic [NR-1:0] cfg_en;
  logic [NR*VB-1:0] cfg_ring_base;
  logic [NR*32-1:0] cfg_ring_bytes;
  logic [31:0]  stat_frames, stat_drops;

  bypass_rx_dma #(.N_REGIONS(NR), .BUF_BEATS(512), .MAX_BEATS(150), .META_DEPTH(16),
                  .VADDR_BITS(VB), .LEN_BITS(28)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_rx_tdata(s_axis_rx_tdata), .s_axis_rx_tkeep(s_axis_rx_tkeep),
    .s_axis_rx_tlast(s_axis_rx_tlast), .s_axis_rx_tid(s_axis_rx_tid),
    .s_axis_rx_tvalid(s_axis_rx_tvalid), .s_axis_rx_tready(s_axis_rx_tready),
    .m_rq_wr_valid(m_rq_wr_valid), .m_rq_wr_ready(m_rq_wr_ready),
    .m_rq_wr_vaddr(m_rq_wr_vaddr), .m_rq_wr_len(m_rq_wr_len), .m_rq_wr_vfid(m_rq_wr_vfid),
    .m_rq_wr_host(m_rq_wr_host), .m_rq_wr_last(m_rq_wr_last),
    .m_axis_wr_tdata(m_axis_wr_tdata), .m_axis_wr_tkeep(m_axis_wr_tkeep),
    .m_axis_wr_tlast(m_axis_wr_tlast), .m_axis_wr_tid(m_axis_wr_tid),
    .m_axis_wr_tdest(m_axis_wr_tdest), .m_axis_wr_tvalid(m_axis_wr_tvalid),
    .m_axis_wr_tready(m_axis_wr_tready),
    .cfg_en(cfg_en), .cfg_ring_base(cfg_ring_base), .cfg_ring_bytes(cfg_ring_bytes),
    .stat_frames(stat_frames), .stat_drops(stat_drops)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [VB-1:0] vaddr; logic [27:0] len; logic [1:0] vfid; } cmd_t;
  typedef struct { logic [511:0] d; logic [63:0] k; logic l; logic [1:0] tid; } beat_t;

  cmd_t  cmd_q[$];
  beat_t beat_q[$];
  cmd_t  mc;
  beat_t mb;
  int total = 0, bad = 0, beats_seen = 0, exp_frames = 0, exp_drops = 0;
  logic [31:0]   roff_m [NR];
  logic [VB-1:0] base_m [NR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] kmask(input int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [511:0] pat(input int id, input int b);
    logic [31:0] w;
    w = {16'(id), 16'(b)};
    return {16{w}};
  endfunction

  // Host ring placement: round up to 64 B, restart at 0 if the frame would not fit.
  function automatic logic [VB-1:0] ring_alloc(input int v, input int nbytes);
    logic [31:0] rlen, off;
    rlen = (32'(nbytes) + 32'd63) & ~32'd63;
    off = (roff_m[v] + rlen > 32'd4096) ? 32'd0 : roff_m[v];
    roff_m[v] = off + rlen;
    return base_m[v] + VB'(off);
  endfunction

  task automatic send_frame(input int v, input int nbytes, input int id, input bit ok);
    int nb;
    cmd_t c;
    beat_t e;
    nb = (nbytes + 63) / 64;
    if (ok) begin
      c.vaddr = ring_alloc(v, nbytes); c.len = 28'(nbytes); c.vfid = 2'(v);
      cmd_q.push_back(c);
      for (int b = 0; b < nb; b++) begin
        e.d = pat(id, b); e.k = (b == nb - 1) ? kmask(nbytes - 64 * b) : '1;
        e.l = (b == nb - 1); e.tid = 2'(v);
        beat_q.push_back(e);
      end
      exp_frames++;
    end else exp_drops++;
    for (int b = 0; b < nb; b++) begin
      s_axis_rx_tvalid = 1'b1;
      s_axis_rx_tdata  = pat(id, b);
      s_axis_rx_tkeep  = (b == nb - 1) ? kmask(nbytes - 64 * b) : '1;
      s_axis_rx_tlast  = (b == nb - 1);
      s_axis_rx_tid    = (b == 0) ? 2'(v) : ~2'(v);  // later-beat tid must be ignored
      @(posedge aclk); #1;
    end
    s_axis_rx_tvalid = 1'b0;
    s_axis_rx_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input int maxc, input string name);
    int n;
    n = 0;
    while ((cmd_q.size() != 0 || beat_q.size() != 0) && n < maxc) begin
      @(posedge aclk); #1; n++;
    end
    if (cmd_q.size() != 0 || beat_q.size() != 0) begin
      total++; bad++;
      $display("FAIL %s drain timeout: %0d cmds and %0d beats outstanding, expected 0",
               name, cmd_q.size(), beat_q.size());
    end
    repeat (4) @(posedge aclk);
    #1;
  endtask

  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_rq_wr_valid && m_rq_wr_ready) begin
        if (cmd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL cmd_unexpected: got vaddr %0h, expected no command", m_rq_wr_vaddr);
        end else begin
          mc = cmd_q.pop_front();
          chk("cmd_vaddr", 64'(m_rq_wr_vaddr), 64'(mc.vaddr));
          chk("cmd_len", 64'(m_rq_wr_len), 64'(mc.len));
          chk("cmd_vfid", 64'(m_rq_wr_vfid), 64'(mc.vfid));
          chk("cmd_host_last", 64'({m_rq_wr_host, m_rq_wr_last}), 64'd3);
        end
      end
      if (m_axis_wr_tvalid && m_axis_wr_tready) begin
        beats_seen++;
        if (beat_q.size() == 0) begin
          total++; bad++;
          $display("FAIL beat_unexpected: got data %0h, expected no beat", m_axis_wr_tdata[31:0]);
        end else begin
          mb = beat_q.pop_front();
          chkw("beat_data", m_axis_wr_tdata, mb.d);
          chk("beat_keep", m_axis_wr_tkeep, mb.k);
          chk("beat_last", 64'(m_axis_wr_tlast), 64'(mb.l));
          chk("beat_tid_tdest", 64'({m_axis_wr_tid, m_axis_wr_tdest}), 64'({mb.tid, 2'b00}));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    s_axis_rx_tvalid = 1'b0; s_axis_rx_tlast = 1'b0; s_axis_rx_tdata = '0;
    s_axis_rx_tkeep = '0; s_axis_rx_tid = '0;
    m_rq_wr_ready = 1'b1; m_axis_wr_tready = 1'b1;
    cfg_en = 4'b1101;
    base_m[0] = 48'h1000; base_m[1] = 48'h10000; base_m[2] = 48'h20000; base_m[3] = 48'h30000;
    cfg_ring_base = {base_m[3], base_m[2], base_m[1], base_m[0]};
    cfg_ring_bytes = {4{32'd4096}};
    for (int i = 0; i < NR; i++) roff_m[i] = '0;

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tready", 64'(s_axis_rx_tready), 64'd1);
    chk("rst_rq_valid", 64'(m_rq_wr_valid), 64'd0);
    chk("rst_tvalid", 64'(m_axis_wr_tvalid), 64'd0);
    chk("rst_frames", 64'(stat_frames), 64'd0);
    chk("rst_drops", 64'(stat_drops), 64'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // 100 B frame to region 0: vaddr 0x1000, two beats
    send_frame(0, 100, 1, 1'b1);
    wait_drain(200, "single");
    chk("single_frames", 64'(stat_frames), 64'd1);

    // 3904 B lands at 0x1080 leaving ring_off 4032; next 128 B wraps to 0x1000
    send_frame(0, 3904, 2, 1'b1);
    send_frame(0, 128, 3, 1'b1);
    wait_drain(400, "wrap");
    chk("wrap_frames", 64'(stat_frames), 64'd3);

    // 160-beat frame exceeds 150 beats: dropped, next 64 B frame intact
    send_frame(0, 160 * 64, 4, 1'b0);
    send_frame(0, 64, 5, 1'b1);
    wait_drain(400, "oversize");
    chk("oversize_drops", 64'(stat_drops), 64'd1);
    chk("oversize_frames", 64'(stat_frames), 64'd4);

    // disabled region 1 dropped, region 2 back-to-back delivered
    send_frame(1, 200, 6, 1'b0);
    send_frame(2, 300, 7, 1'b1);
    wait_drain(200, "disabled");
    chk("disabled_drops", 64'(stat_drops), 64'd2);
    chk("disabled_frames", 64'(stat_frames), 64'd5);

    // 20 x 1500 B with egress stalled: 16 fit the 512-beat buffer, 4 dropped
    m_axis_wr_tready = 1'b0;
    for (int i = 0; i < 20; i++) send_frame(3, 1500, 10 + i, i < 16);
    repeat (520) @(posedge aclk);
    #1;
    m_axis_wr_tready = 1'b1;
    wait_drain(3000, "overflow");
    chk("overflow_frames", 64'(stat_frames), 64'd21);
    chk("overflow_drops", 64'(stat_drops), 64'd6);
    chk("overflow_sum", 64'(stat_frames + stat_drops), 64'(exp_frames + exp_drops));

    // reset while frame 3 of 5 is mid-burst
    m_axis_wr_tready = 1'b0;
    beats_seen = 0;
    for (int i = 0; i < 5; i++) send_frame(0, 192, 40 + i, 1'b1);
    repeat (4) @(posedge aclk);
    #1;
    m_axis_wr_tready = 1'b1;
    n = 0;
    while (beats_seen < 7 && n < 200) begin
      @(posedge aclk); #1; n++;
    end
    chk("midburst_reached", 64'(beats_seen >= 7), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("rst_mid_tvalid", 64'(m_axis_wr_tvalid), 64'd0);
    chk("rst_mid_rq_valid", 64'(m_rq_wr_valid), 64'd0);
    cmd_q.delete();
    beat_q.delete();
    for (int i = 0; i < NR; i++) roff_m[i] = '0;
    exp_frames = 0; exp_drops = 0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("post_rst_frames", 64'(stat_frames), 64'd0);
    chk("post_rst_drops", 64'(stat_drops), 64'd0);
    send_frame(0, 64, 50, 1'b1);
    wait_drain(200, "post_rst");
    repeat (20) @(posedge aclk);
    #1;
    chk("post_rst_final_frames", 64'(stat_frames), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
